// File: rtl/binary_matvec_seq_if.sv
// binary_matvec_seq_if: operand/result handshake bundle for binary_matvec_seq.
// The slave modport is the compute block; the master modport is the producer/consumer side.
interface binary_matvec_seq_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [N*N-1:0] mat;
  logic [N-1:0]   vec;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   res;
  logic           busy;

  modport master (
    output in_valid, mat, vec, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  in_valid, mat, vec, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/binary_matvec_seq.sv
// binary_matvec_seq: N x N binary matrix times N-bit vector, one result row per cycle.
// Define BINARY_MATVEC_GF2_EN for XOR (GF(2)) row reduction; the default build reduces rows with OR.
module binary_matvec_seq #(
  parameter int N = 4
) (
  input logic                clk,
  input logic                rst_n,
  binary_matvec_seq_if.slave bus
);
  localparam int RW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_nx_s;
  logic [N*N-1:0] mat_r;
  logic [N-1:0]   vec_r;
  logic [RW-1:0]  row_r;
  logic [N-1:0]   res_r;
  logic [N-1:0]   res_nx_s;
  logic [N-1:0]   row_bits_s;
  logic           last_row_s;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           busy_r;

  function automatic logic reduce_row(input logic [N-1:0] bits);
`ifdef BINARY_MATVEC_GF2_EN
    return ^bits;
`else
    return |bits;
`endif
  endfunction

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.res       = res_r;

  assign last_row_s = (row_r == RW'(N - 1));

  // Select the current matrix row and merge its reduced product into the result.
  always_comb begin
    row_bits_s = '0;
    res_nx_s   = res_r;
    for (int r = 0; r < N; r++) begin
      if (row_r == RW'(r)) begin
        row_bits_s  = mat_r[r*N +: N] & vec_r;
        res_nx_s[r] = reduce_row(mat_r[r*N +: N] & vec_r);
      end else begin
        res_nx_s[r] = res_r[r];
      end
    end
  end

  // Next-state decode for the IDLE -> COMPUTE -> DONE sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) state_nx_s = COMPUTE;
        else              state_nx_s = IDLE;
      end
      COMPUTE: begin
        if (last_row_s) state_nx_s = DONE;
        else            state_nx_s = COMPUTE;
      end
      DONE: begin
        if (bus.out_ready) state_nx_s = IDLE;
        else               state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register; status outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s != IDLE);
    end
  end

  // Operand capture and row-by-row result accumulation; the counter parks at N once all rows are done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mat_r <= '0;
      vec_r <= '0;
      row_r <= '0;
      res_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            mat_r <= bus.mat;
            vec_r <= bus.vec;
            row_r <= '0;
            res_r <= '0;
          end else begin
            res_r <= res_r;
          end
        end
        COMPUTE: begin
          res_r <= res_nx_s;
          row_r <= row_r + RW'(1);
        end
        default: res_r <= res_r;
      endcase
    end
  end
endmodule

// File: tb/tb_binary_matvec_seq.sv
// tb_binary_matvec_seq: scoreboard bench for an N=4 instance (directed jobs) and an N=2 instance (full sweep).
module tb_binary_matvec_seq;
  logic clk = 1'b0;
  logic rst_n4 = 1'b0;
  logic rst_n2 = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   accept_cyc4 = 0;
  logic prev4 = 1'b0;
  logic [3:0] q4[$];
  logic [1:0] q2[$];
  logic [3:0] e4;
  logic [1:0] e2;

`ifdef BINARY_MATVEC_GF2_EN
  localparam logic [3:0] EXP_ONES = 4'b0000;
`else
  localparam logic [3:0] EXP_ONES = 4'b1111;
`endif

  binary_matvec_seq_if #(.N(4)) b4 ();
  binary_matvec_seq_if #(.N(2)) b2 ();

  binary_matvec_seq #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n4), .bus(b4));
  binary_matvec_seq #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n2), .bus(b2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [1:0] model2(input logic [3:0] m, input logic [1:0] v);
    logic [1:0] r2;
    logic acc;
    r2 = 2'b00;
    for (int r = 0; r < 2; r++) begin
      acc = 1'b0;
      for (int c = 0; c < 2; c++) begin
`ifdef BINARY_MATVEC_GF2_EN
        if (m[r*2+c] && v[c]) acc = ~acc;
`else
        if (m[r*2+c] && v[c]) acc = 1'b1;
`endif
      end
      r2[r] = acc;
    end
    return r2;
  endfunction

  // Monitor for the N=4 instance: latency on each rising out_valid, result on each output handshake.
  always @(negedge clk) begin
    if (b4.out_valid === 1'b1 && prev4 === 1'b0) chk("latency4", cyc - accept_cyc4, 4);
    prev4 <= b4.out_valid;
    if (b4.out_valid === 1'b1 && b4.out_ready === 1'b1) begin
      if (q4.size() == 0) chk("unexpected_out4", q4.size(), 1);
      else begin
        e4 = q4.pop_front();
        chk("res4", b4.res, e4);
      end
    end
  end

  // Monitor for the N=2 instance.
  always @(negedge clk) begin
    if (b2.out_valid === 1'b1 && b2.out_ready === 1'b1) begin
      if (q2.size() == 0) chk("unexpected_out2", q2.size(), 1);
      else begin
        e2 = q2.pop_front();
        chk("res2", b2.res, e2);
      end
    end
  end

  task automatic send4(input logic [15:0] m, input logic [3:0] v, input logic [3:0] e);
    int t = 0;
    while (b4.in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    if (b4.in_ready !== 1'b1) chk("in_ready4_timeout", b4.in_ready, 1);
    b4.in_valid = 1'b1; b4.mat = m; b4.vec = v;
    @(posedge clk); #1;
    accept_cyc4 = cyc;
    b4.in_valid = 1'b0;
    q4.push_back(e);
  endtask

  task automatic send2(input logic [3:0] m, input logic [1:0] v, output int acc_cyc);
    int t = 0;
    while (b2.in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    if (b2.in_ready !== 1'b1) chk("in_ready2_timeout", b2.in_ready, 1);
    b2.in_valid = 1'b1; b2.mat = m; b2.vec = v;
    @(posedge clk); #1;
    acc_cyc = cyc;
    b2.in_valid = 1'b0;
    q2.push_back(model2(m, v));
  endtask

  task automatic drain4();
    int t = 0;
    while (q4.size() != 0 && t < 40) begin @(posedge clk); #1; t++; end
    chk("drain4_timeout", q4.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int acc;
    int last_acc;
    logic seen;
    b4.in_valid = 1'b0; b4.mat = 16'h0000; b4.vec = 4'h0; b4.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.mat = 4'h0;     b2.vec = 2'h0; b2.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready4", b4.in_ready, 1);
    chk("rst_out_valid4", b4.out_valid, 0);
    chk("rst_busy4", b4.busy, 0);
    chk("rst_res4", b4.res, 0);
    chk("rst_in_ready2", b2.in_ready, 1);
    chk("rst_res2", b2.res, 0);
    rst_n4 = 1'b1; rst_n2 = 1'b1;
    @(posedge clk); #1;

    // identity matrix returns the vector
    send4(16'h8421, 4'b1011, 4'b1011);
    chk("busy4_compute", b4.busy, 1);
    drain4();

    // all-ones matrix: OR gives ones, XOR gives parity of two ones
    send4(16'hFFFF, 4'b0011, EXP_ONES);
    drain4();

    // back-pressure: result must hold while out_ready is low
    b4.out_ready = 1'b0;
    send4(16'h00F0, 4'b0111, 4'b0010);
    t = 0;
    while (b4.out_valid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    chk("hold_reach_done", b4.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", b4.out_valid, 1);
      chk("hold_res", b4.res, 4'b0010);
      chk("hold_in_ready", b4.in_ready, 0);
    end
    b4.out_ready = 1'b1;
    drain4();

    // operands changed and in_valid pulsed after capture must be ignored
    send4(16'h1234, 4'b1010, 4'b0110);
    b4.mat = 16'hFFFF; b4.vec = 4'hF; b4.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("ignore_in_ready", b4.in_ready, 0);
    chk("ignore_busy", b4.busy, 1);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    drain4();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (b4.out_valid === 1'b1) seen = 1'b1;
    end
    chk("no_phantom_job", seen, 0);

    // reset while row 2 is being evaluated aborts the job
    send4(16'h8421, 4'b1111, 4'b1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n4 = 1'b0;
    @(posedge clk); #1;
    rst_n4 = 1'b1;
    q4.delete();
    chk("abort_res", b4.res, 0);
    chk("abort_out_valid", b4.out_valid, 0);
    chk("abort_busy", b4.busy, 0);
    chk("abort_in_ready", b4.in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (b4.out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_out_valid", seen, 0);
    send4(16'h8421, 4'b0110, 4'b0110);
    drain4();

    // N=2 exhaustive back-to-back sweep
    last_acc = 0;
    for (int m = 0; m < 16; m++) begin
      for (int v = 0; v < 4; v++) begin
        send2(4'(m), 2'(v), acc);
        if (m != 0 || v != 0) chk("interval2", acc - last_acc, 4);
        last_acc = acc;
      end
    end
    t = 0;
    while (q2.size() != 0 && t < 40) begin @(posedge clk); #1; t++; end
    chk("drain2_timeout", q2.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("q4_empty", q4.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
